// File: rtl/ft245_device_model_if.sv
// FT245 synchronous FIFO handshake strobes and flags.
// The master modport is the FPGA-side controller; the slave modport is the device model.
interface ft245_device_model_if;
  logic _rd;
  logic _wr;
  logic _oe;
  logic _txe;
  logic _rxf;

  modport master (output _rd, output _wr, output _oe, input _txe, input _rxf);
  modport slave  (input _rd, input _wr, input _oe, output _txe, output _rxf);
endinterface

// File: rtl/ft245_device_model.sv
// Device end of an FT245 synchronous FIFO bus: the RX FIFO is loaded by the host port
// and read over the bus; the TX FIFO is written over the bus and drained by the host port.
module ft245_device_model #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              _reset,
  ft245_device_model_if.slave bus,
  inout  wire  [7:0]        data,
  input  logic              host_wr_en,
  input  logic [7:0]        host_wr_data,
  output logic              host_full,
  input  logic              host_rd_en,
  output logic [7:0]        host_rd_data,
  output logic              host_empty,
  output logic [ADDR_W:0]   rx_count,
  output logic [ADDR_W:0]   tx_count,
  output logic [2:0]        err,
  input  logic              err_clr
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TURN  = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;

  logic [1:0]        state;
  logic              drive;
  logic [7:0]        rx_mem [DEPTH];
  logic [7:0]        tx_mem [DEPTH];
  logic [ADDR_W-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [ADDR_W:0]   rx_count_nxt, tx_count_nxt;
  logic              rx_push, rx_pop, tx_push, tx_pop;
  logic [2:0]        err_new;

  assign drive = (state == DRIVE);
  // Released combinationally from state, so an async reset floats the bus at once.
  assign data  = drive ? rx_mem[rx_rp] : 8'hzz;

  assign host_full    = (rx_count == FULL_CNT);
  assign host_empty   = (tx_count == '0);
  assign host_rd_data = tx_mem[tx_rp];

  assign rx_push = host_wr_en && !host_full;
  assign rx_pop  = !bus._rd && !bus._rxf && drive;
  assign tx_push = !bus._wr && !bus._txe && bus._oe;
  assign tx_pop  = host_rd_en && !host_empty;

  // A read strobe with data pending but the bus not yet turned around is a protocol error.
  assign err_new[0] = !bus._rd && !bus._rxf && !drive;
  assign err_new[1] = !bus._wr && !bus._oe;
  assign err_new[2] = host_wr_en && host_full;

  always_comb begin
    rx_count_nxt = rx_count;
    if (rx_push && !rx_pop)      rx_count_nxt = rx_count + 1'b1;
    else if (!rx_push && rx_pop) rx_count_nxt = rx_count - 1'b1;
  end

  always_comb begin
    tx_count_nxt = tx_count;
    if (tx_push && !tx_pop)      tx_count_nxt = tx_count + 1'b1;
    else if (!tx_push && tx_pop) tx_count_nxt = tx_count - 1'b1;
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= bus._oe ? IDLE : TURN;
        TURN:    state <= bus._oe ? IDLE : DRIVE;
        DRIVE:   state <= bus._oe ? IDLE : DRIVE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      tx_wp    <= '0;
      tx_rp    <= '0;
      rx_count <= '0;
      tx_count <= '0;
      bus._rxf <= 1'b1;
      bus._txe <= 1'b1;
      err      <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      rx_count <= rx_count_nxt;
      tx_count <= tx_count_nxt;
      bus._rxf <= (rx_count_nxt == '0);
      bus._txe <= (tx_count_nxt == FULL_CNT);
      err      <= (err_clr ? 3'b000 : err) | err_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= host_wr_data;
    if (tx_push) tx_mem[tx_wp] <= data;
  end
endmodule

// File: tb/tb_ft245_device_model.sv
// Scoreboard bench for ft245_device_model: expected bytes are queued when pushed and
// compared as the bus or host port pops them.
module tb_ft245_device_model;
  logic       clk = 1'b0;
  logic       _reset = 1'b0;
  logic       host_wr_en = 1'b0;
  logic [7:0] host_wr_data = 8'h00;
  logic       host_full;
  logic       host_rd_en = 1'b0;
  logic [7:0] host_rd_data;
  logic       host_empty;
  logic [4:0] rx_count, tx_count;
  logic [2:0] err;
  logic       err_clr = 1'b0;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_data = 8'h00;
  wire  [7:0] data;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp;

  ft245_device_model_if bus ();

  assign data = tb_drv ? tb_data : 8'hzz;

  ft245_device_model #(.ADDR_W(4)) dut (
    .clk(clk), ._reset(_reset), .bus(bus.slave), .data(data),
    .host_wr_en(host_wr_en), .host_wr_data(host_wr_data), .host_full(host_full),
    .host_rd_en(host_rd_en), .host_rd_data(host_rd_data), .host_empty(host_empty),
    .rx_count(rx_count), .tx_count(tx_count), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus._rd = 1'b1; bus._wr = 1'b1; bus._oe = 1'b1;
    host_wr_en = 1'b0; host_rd_en = 1'b0; err_clr = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rx_q.delete(); tx_q.delete();
    _reset = 1'b0;
    tick(); tick();
    #2 _reset = 1'b1;
  endtask

  task automatic host_push(input logic [7:0] b);
    host_wr_en = 1'b1; host_wr_data = b;
    tick();
    host_wr_en = 1'b0;
    rx_q.push_back(b);
  endtask

  task automatic enter_drive;
    bus._oe = 1'b0;
    tick(); tick();
    checks++;
    if (dut.drive !== 1'b1) begin errors++; $display("FAIL drive_after_turn: got %b want 1", dut.drive); end
  endtask

  // One bus pop: the byte on the bus before the edge must be the scoreboard head.
  task automatic bus_pop_check(input string name);
    exp = rx_q.pop_front();
    checks++;
    if (data !== exp) begin errors++; $display("FAIL %s: data got %h want %h", name, data, exp); end
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    _reset = 1'b0;
    tick();
    checks++;
    if ({bus._txe, bus._rxf, host_full, host_empty, rx_count, tx_count, err, dut.drive} !== {1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: txe=%b rxf=%b full=%b empty=%b rxc=%0d txc=%0d err=%b drive=%b want 1 1 0 1 0 0 000 0",
               bus._txe, bus._rxf, host_full, host_empty, rx_count, tx_count, err, dut.drive);
    end
    #2 _reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus._txe, bus._rxf, err, dut.drive} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
        errors++;
        $display("FAIL idle_cycle%0d: txe=%b rxf=%b err=%b drive=%b want 0 1 000 0", i, bus._txe, bus._rxf, err, dut.drive);
      end
    end
  endtask

  task automatic test_bus_read;
    do_reset();
    host_push(8'h11); host_push(8'h22); host_push(8'h33);
    checks++;
    if (bus._rxf !== 1'b0) begin errors++; $display("FAIL rxf_after_push: got %b want 0", bus._rxf); end
    enter_drive();
    bus._rd = 1'b0;
    for (int i = 0; i < 3; i++) bus_pop_check("bus_read");
    bus._rd = 1'b1;
    checks++;
    if ({bus._rxf, rx_count} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL read_drained: rxf=%b rxc=%0d want 1 0", bus._rxf, rx_count);
    end
    bus._oe = 1'b1;
    tick();
    checks++;
    if (dut.drive !== 1'b0) begin errors++; $display("FAIL release_on_oe: drive got %b want 0", dut.drive); end
  endtask

  task automatic test_rd_no_oe;
    do_reset();
    host_push(8'hA1); host_push(8'hA2);
    bus._rd = 1'b0;
    tick();
    bus._rd = 1'b1;
    checks++;
    if ({rx_count, err} !== {5'd2, 3'b001}) begin
      errors++; $display("FAIL rd_no_oe: rxc=%0d err=%b want 2 001", rx_count, err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 3'b000) begin errors++; $display("FAIL err_clr: got %b want 000", err); end
  endtask

  task automatic test_bus_write;
    do_reset();
    tick();
    tb_drv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus._wr = 1'b0; tb_data = 8'(i);
      tick();
      tx_q.push_back(8'(i));
    end
    checks++;
    if ({bus._txe, tx_count} !== {1'b1, 5'd16}) begin
      errors++; $display("FAIL tx_full: txe=%b txc=%0d want 1 16", bus._txe, tx_count);
    end
    tb_data = 8'hAA;
    tick();
    bus._wr = 1'b1; tb_drv = 1'b0;
    checks++;
    if (tx_count !== 5'd16) begin errors++; $display("FAIL tx_overfill: txc=%0d want 16", tx_count); end
    for (int i = 0; i < 16; i++) begin
      exp = tx_q.pop_front();
      checks++;
      if (host_rd_data !== exp) begin errors++; $display("FAIL host_pop: got %h want %h", host_rd_data, exp); end
      host_rd_en = 1'b1;
      tick();
    end
    host_rd_en = 1'b0;
    checks++;
    if ({host_empty, tx_count, bus._txe} !== {1'b1, 5'd0, 1'b0}) begin
      errors++; $display("FAIL tx_drained: empty=%b txc=%0d txe=%b want 1 0 0", host_empty, tx_count, bus._txe);
    end
    // write while the controller holds _oe low is rejected
    bus._oe = 1'b0; bus._wr = 1'b0; tb_drv = 1'b1; tb_data = 8'h5A;
    tick();
    bus._oe = 1'b1; bus._wr = 1'b1; tb_drv = 1'b0;
    checks++;
    if ({tx_count, err} !== {5'd0, 3'b010}) begin
      errors++; $display("FAIL wr_while_oe: txc=%0d err=%b want 0 010", tx_count, err);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    tick();
    tb_drv = 1'b1; bus._wr = 1'b0; tb_data = 8'h50;
    tick();
    tb_data = 8'h51; host_rd_en = 1'b1;
    checks++;
    if (host_rd_data !== 8'h50) begin errors++; $display("FAIL tx_b2b_head: got %h want 50", host_rd_data); end
    tick();
    bus._wr = 1'b1; tb_drv = 1'b0; host_rd_en = 1'b0;
    checks++;
    if ({tx_count, host_rd_data} !== {5'd1, 8'h51}) begin
      errors++; $display("FAIL tx_b2b: txc=%0d head=%h want 1 51", tx_count, host_rd_data);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 16; i++) host_push(8'h80 + 8'(i));
    checks++;
    if ({host_full, rx_count} !== {1'b1, 5'd16}) begin
      errors++; $display("FAIL rx_full: full=%b rxc=%0d want 1 16", host_full, rx_count);
    end
    enter_drive();
    bus._rd = 1'b0; host_wr_en = 1'b1; host_wr_data = 8'hEE;
    bus_pop_check("pop_at_full");
    host_wr_en = 1'b0;
    checks++;
    if ({rx_count, err[2]} !== {5'd15, 1'b1}) begin
      errors++; $display("FAIL push_at_full: rxc=%0d err2=%b want 15 1", rx_count, err[2]);
    end
    for (int i = 0; i < 7; i++) bus_pop_check("pop_to_8");
    host_wr_en = 1'b1; host_wr_data = 8'h77;
    bus_pop_check("pop_with_push");
    rx_q.push_back(8'h77);
    host_wr_en = 1'b0;
    checks++;
    if (rx_count !== 5'd8) begin errors++; $display("FAIL push_pop_count: rxc=%0d want 8", rx_count); end
    for (int i = 0; i < 8; i++) bus_pop_check("order_after_push_pop");
    bus._rd = 1'b1; bus._oe = 1'b1;
    checks++;
    if ({rx_count, bus._rxf} !== {5'd0, 1'b1}) begin
      errors++; $display("FAIL overflow_drained: rxc=%0d rxf=%b want 0 1", rx_count, bus._rxf);
    end
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    tick();
    tb_drv = 1'b1; bus._wr = 1'b0; tb_data = 8'h3C;
    tick();
    tb_drv = 1'b0; bus._wr = 1'b1;
    for (int i = 0; i < 4; i++) host_push(8'hC0 + 8'(i));
    enter_drive();
    bus._rd = 1'b0;
    bus_pop_check("pop_before_reset");
    #2 _reset = 1'b0;
    #1;
    checks++;
    if ({dut.drive, rx_count, tx_count, bus._rxf} !== {1'b0, 5'd0, 5'd0, 1'b1}) begin
      errors++; $display("FAIL async_reset: drive=%b rxc=%0d txc=%0d rxf=%b want 0 0 0 1", dut.drive, rx_count, tx_count, bus._rxf);
    end
    tick();
    _reset = 1'b1;
    #1;
    checks++;
    if (dut.state !== 2'd0) begin errors++; $display("FAIL state_after_release: got %0d want 0", dut.state); end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_bus_read();
    test_rd_no_oe();
    test_bus_write();
    test_back_to_back();
    test_overflow();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ft245_device_model.md
Name: ft245_device_model

Overview:
- Synthesizable model of the FTDI device end of the FT245 synchronous FIFO bus.
- Drives _txe, _rxf and the data bus, and accepts the FPGA-side _rd/_wr/_oe strobes.
- Contains an RX FIFO (host→FPGA bytes, loaded from a host-side port) and a TX FIFO (FPGA→host bytes, drained by a host-side port).
- Used for on-chip loopback and bench bring-up of the FPGA-side FT245 controller without a physical FTDI part.

Parameters:
- ADDR_W, 4, log2 depth of each FIFO (16 entries).

Ports:
- clk  in  1  bus clock (CLKOUT equivalent).
- _reset  in  1  asynchronous reset, active low.
- _rd  in  1  read strobe from the controller, low = read.
- _wr  in  1  write strobe from the controller, low = write.
- _oe  in  1  output enable from the controller, low = device may drive data.
- _txe  out  1  low = TX FIFO can accept a byte.
- _rxf  out  1  low = RX FIFO holds a byte.
- data  inout  8  bidirectional FT245 data bus.
- host_wr_en  in  1  push host_wr_data into the RX FIFO.
- host_wr_data  in  8  byte for the RX FIFO.
- host_full  out  1  RX FIFO full.
- host_rd_en  in  1  pop the TX FIFO.
- host_rd_data  out  8  TX FIFO head (first-word fall-through).
- host_empty  out  1  TX FIFO empty.
- rx_count  out  ADDR_W+1  RX FIFO occupancy.
- tx_count  out  ADDR_W+1  TX FIFO occupancy.
- err  out  3  sticky errors: [0] rd_no_oe, [1] wr_while_oe, [2] host_overflow.
- err_clr  in  1  synchronous clear of err.

Behaviour:
- All state is reset asynchronously on _reset=0.
- Reset values:
  - _txe=1, _rxf=1.
  - host_full=0, host_empty=1, rx_count=0, tx_count=0, err=0.
  - Bus FSM in IDLE, data released to Z, FIFO pointers 0.
  - host_rd_data is don't-care while host_empty=1.
- Flags:
  - _txe and _rxf are registered.
  - _rxf_next = (rx_count_next==0); _txe_next = (tx_count_next==2^ADDR_W).
  - Consequently, the cycle after reset deassertion _txe=0.
  - After a pop of the last RX byte, _rxf goes high on that same edge, so it is visible the following cycle.
- Bus-direction FSM (registered; evaluated each posedge):
  - IDLE: data released. If _oe=0 → TURN.
  - TURN: one turnaround cycle, data still released. If _oe=0 → DRIVE, else → IDLE.
  - DRIVE: data driven with the RX FIFO head, combinationally from the read pointer. If _oe=1 → IDLE, and data is released in the cycle the FSM reaches IDLE.
- Bus read:
  - On posedge with _rd=0, _rxf=0 and state==DRIVE: pop RX FIFO.
  - The next byte appears on data after that edge, giving one byte per clock while _rd is held low.
  - If _rd=0 while state!=DRIVE: no pop, and err[0] is set.
  - If _rd=0 with _rxf=1: no pop, no error.
- Bus write:
  - On posedge with _wr=0, _txe=0 and _oe=1: push data into the TX FIFO.
  - If _wr=0 and _oe=0: write ignored, err[1] set.
  - If _wr=0 with _txe=1: dropped silently.
- Host side:
  - host_wr_en while host_full=1: byte dropped, err[2] set.
  - host_rd_en while host_empty=1: ignored.
  - host_full and host_empty are combinational from the counts.
- Simultaneous events:
  - Host push and bus pop on the same RX edge: both occur, rx_count unchanged.
  - Bus push and host pop on TX: both occur.
  - A push into a full FIFO is never accepted, even when a pop happens on the same edge.
- Pointers and counts:
  - Pointers are ADDR_W bits and wrap modulo 2^ADDR_W.
  - Counts are ADDR_W+1 bits, saturating at 2^ADDR_W by construction.
- err_clr has priority below new error events: an error arriving on the clear edge remains set.
- Reset mid-transfer: bus released immediately (asynchronous), FIFOs emptied, in-flight byte lost.

Test Plan:
- Reset, then 3 clocks idle → _txe=0 from cycle 1, _rxf=1, data=Z, err=0.
- Host pushes 0x11,0x22,0x33; controller drives _oe=0 at cycle t and _rd=0 at t+2 for 3 clocks → data shows 0x11,0x22,0x33 on consecutive edges; _rxf=1 after the third pop; rx_count=0.
- _rd=0 with _oe=1 while rx_count=2 → no pop, rx_count stays 2, err[0]=1; err_clr pulse → err=0.
- Controller writes 16 bytes 0x00..0x0F with _wr=0 → _txe=1 after the 16th edge; a 17th byte 0xAA is not stored; host pops all 16 in order 0x00..0x0F; host_empty=1.
- RX FIFO at 16 with simultaneous host_wr_en=1 and bus pop → push rejected, err[2]=1, rx_count=15; at count 8, simultaneous push+pop → rx_count stays 8 and the order is preserved.
- _reset asserted mid-burst with _oe=0 and _rd=0 → data=Z the same cycle, rx_count=tx_count=0, _rxf=1, FSM in IDLE after release.
